// File: rtl/encr_buf_pkg.sv
// Shared types and sizes for the ciphertext output buffer.
package encr_buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } buf_state_t;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 128;
    localparam int ADDR_W      = 32;

endpackage

// File: rtl/encr_block_fifo.sv
// Synchronous block FIFO; pointers carry an extra wrap bit so full/empty need no counter.
module encr_block_fifo #(
    parameter int DEPTH   = 4,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [BLOCK_W-1:0] din,
    output logic [BLOCK_W-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = 1;

    logic [IDX_W:0]      wr_ptr;
    logic [IDX_W:0]      rd_ptr;
    logic [BLOCK_W-1:0]  mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is deliberately left unreset; the consumer masks it while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign dout  = mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/encr_output_buffer.sv
// Queues AES ciphertext blocks and hands them to the AHB-Lite master with
// incrementing destination addresses, retrying failed writes a bounded number of times.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | accepting blocks and issuing transfers
//   ERROR | retry limit hit; queue and address frozen until start
module encr_output_buffer
    import encr_buf_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               aes_valid,
    input  logic [BLOCK_W-1:0] aes_text,
    output logic               aes_ready,
    output logic               xfer_req,
    output logic [BLOCK_W-1:0] destination,
    output logic [BLOCK_W-1:0] encr_text,
    input  logic               xfer_done,
    input  logic               xfer_err,
    output logic [15:0]        blocks_written,
    output logic               error
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_ONE = 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [ADDR_W-1:0]  ADDR_STEP = ADDR_W'(BLOCK_BYTES);

    buf_state_t         state;
    buf_state_t         state_nxt;
    logic [ADDR_W-1:0]  addr;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_inc;
    logic [BLOCK_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               run;
    logic               push;
    logic               pop;
    logic               err_hit;

    assign run       = (state == RUN);
    assign aes_ready = run && !fifo_full;
    assign xfer_req  = run && !fifo_empty;

    // start outranks everything; an error response outranks a same-cycle done.
    assign push      = aes_valid && aes_ready && !start;
    assign err_hit   = xfer_err && xfer_req && !start;
    assign pop       = xfer_done && xfer_req && !xfer_err && !start;
    assign retry_inc = retry + RETRY_ONE;

    encr_block_fifo #(
        .DEPTH   (DEPTH),
        .BLOCK_W (BLOCK_W)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (push),
        .pop   (pop),
        .flush (start),
        .din   (aes_text),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else if (err_hit && (retry_inc == RETRY_MAX)) begin
            state_nxt = ERROR;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr           <= '0;
            retry          <= '0;
            blocks_written <= '0;
        end else if (start) begin
            addr           <= base_addr;
            retry          <= '0;
            blocks_written <= '0;
        end else if (err_hit) begin
            retry <= retry_inc;
        end else if (pop) begin
            addr           <= addr + ADDR_STEP;
            retry          <= '0;
            blocks_written <= blocks_written + 16'd1;
        end
    end

    assign destination = {{(BLOCK_W - ADDR_W){1'b0}}, addr};
    assign encr_text   = xfer_req ? head : '0;
    assign error       = (state == ERROR);

endmodule

// File: tb/tb_encr_output_buffer.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_encr_output_buffer;

    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 3;

    logic         HCLK = 1'b0;
    logic         HRESET = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic         aes_valid = 1'b0;
    logic [127:0] aes_text = '0;
    logic         aes_ready;
    logic         xfer_req;
    logic [127:0] destination;
    logic [127:0] encr_text;
    logic         xfer_done = 1'b0;
    logic         xfer_err = 1'b0;
    logic [15:0]  blocks_written;
    logic         error;

    encr_output_buffer #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .start          (start),
        .base_addr      (base_addr),
        .aes_valid      (aes_valid),
        .aes_text       (aes_text),
        .aes_ready      (aes_ready),
        .xfer_req       (xfer_req),
        .destination    (destination),
        .encr_text      (encr_text),
        .xfer_done      (xfer_done),
        .xfer_err       (xfer_err),
        .blocks_written (blocks_written),
        .error          (error)
    );

    always #5 HCLK = ~HCLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: 0 = idle, 1 = run, 2 = error
    logic [127:0] q[$];
    logic [31:0]  m_addr;
    logic [15:0]  m_bw;
    int           m_retry;
    int           m_mode;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_addr  = '0;
        m_bw    = '0;
        m_retry = 0;
        m_mode  = 0;
    endtask

    task automatic check_all();
        logic         m_req;
        logic         m_rdy;
        m_req = (m_mode == 1) && (q.size() > 0);
        m_rdy = (m_mode == 1) && (q.size() < DEPTH);
        check("aes_ready", aes_ready, m_rdy);
        check("xfer_req", xfer_req, m_req);
        check("error", error, m_mode == 2);
        check("destination", destination, {96'b0, m_addr});
        check("encr_text", encr_text, m_req ? q[0] : 128'b0);
        check("blocks_written", blocks_written, m_bw);
    endtask

    task automatic step(input bit st, input logic [31:0] ba, input bit v,
                        input logic [127:0] t, input bit d, input bit e);
        bit had;
        bit was_full;
        start = st; base_addr = ba; aes_valid = v; aes_text = t;
        xfer_done = d; xfer_err = e;
        @(posedge HCLK);
        if (st) begin
            q.delete();
            m_addr = ba; m_bw = '0; m_retry = 0; m_mode = 1;
        end else if (m_mode == 1) begin
            had      = q.size() > 0;
            was_full = q.size() >= DEPTH;
            if (e && had) begin
                m_retry++;
                if (m_retry == MAX_RETRY) m_mode = 2;
            end else if (d && had) begin
                void'(q.pop_front());
                m_addr  = m_addr + 32'd16;
                m_bw    = m_bw + 16'd1;
                m_retry = 0;
            end
            if (v && !was_full) q.push_back(t);
        end
        @(negedge HCLK);
        check_all();
    endtask

    task automatic idle(); step(0, 0, 0, '0, 0, 0); endtask
    task automatic push(input logic [127:0] t); step(0, 0, 1, t, 0, 0); endtask
    task automatic done(); step(0, 0, 0, '0, 1, 0); endtask
    task automatic err(); step(0, 0, 0, '0, 0, 1); endtask
    task automatic go(input logic [31:0] ba); step(1, ba, 0, '0, 0, 0); endtask

    logic [127:0] blk_a, blk_b, blk_c, blk_e, rnd;

    initial begin
        model_reset();
        blk_a = {4{32'hAAAA_0001}};
        blk_b = {4{32'hBBBB_0002}};
        blk_c = {4{32'hCCCC_0003}};
        blk_e = {4{32'hEEEE_0005}};

        #12;
        check_all();
        check("reset_dest", destination, 128'b0);
        @(negedge HCLK);
        HRESET = 1'b0;
        idle();

        // In-order delivery with incrementing addresses
        go(32'h1000);
        check("ready_after_start", aes_ready, 1'b1);
        push(blk_a); push(blk_b); push(blk_c);
        check("dest_a", destination[31:0], 32'h1000);
        check("text_a", encr_text, blk_a);
        done();
        check("dest_b", destination[31:0], 32'h1010);
        check("text_b", encr_text, blk_b);
        done();
        check("dest_c", destination[31:0], 32'h1020);
        check("text_c", encr_text, blk_c);
        done();
        check("bw_three", blocks_written, 16'd3);
        check("req_low_drained", xfer_req, 1'b0);

        // Full back-pressure; a pop frees a slot only on the following cycle
        for (int i = 0; i < 4; i++) push({4{32'hD000_0000 + 32'(i)}});
        check("ready_full", aes_ready, 1'b0);
        push(blk_e);
        step(0, 0, 1, blk_e, 1, 0);
        check("ready_after_pop", aes_ready, 1'b1);
        push(blk_e);
        check("ready_refull", aes_ready, 1'b0);

        // Two errors hold the head, then a done retires it
        err();
        check("hold_dest_1", destination[31:0], 32'h1040);
        err();
        check("hold_dest_2", destination[31:0], 32'h1040);
        done();
        check("dest_after_retry", destination[31:0], 32'h1050);

        // Three consecutive errors latch ERROR
        err(); err(); err();
        check("error_set", error, 1'b1);
        check("error_req", xfer_req, 1'b0);
        check("error_ready", aes_ready, 1'b0);
        push(blk_a); done();
        go(32'h0);
        check("restart_error", error, 1'b0);
        check("restart_req", xfer_req, 1'b0);
        check("restart_dest", destination, 128'b0);

        // Address wrap at the top of the 32-bit space
        go(32'hFFFF_FFF0);
        push(blk_a); push(blk_b);
        done();
        check("wrap_dest", destination[31:0], 32'h0);
        done();

        // Asynchronous reset mid-stream
        push(blk_a); push(blk_b);
        #2 HRESET = 1'b1;
        #1;
        model_reset();
        check("rst_ready", aes_ready, 1'b0);
        check("rst_req", xfer_req, 1'b0);
        check("rst_dest", destination, 128'b0);
        check("rst_text", encr_text, 128'b0);
        check("rst_bw", blocks_written, 16'd0);
        check("rst_error", error, 1'b0);
        @(negedge HCLK);
        HRESET = 1'b0;
        idle();
        push(blk_c);
        check("idle_ignores_push", xfer_req, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom % 50) == 0,
                 (($urandom % 4) == 0) ? 32'hFFFF_FFC0 : $urandom,
                 $urandom % 2, rnd,
                 ($urandom % 3) == 0,
                 ($urandom % 10) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
